// File: rtl/a12_edge_qual_if.sv
// Signal bundle between the A12 edge qualifier and its stimulus/consumer side.
// The qualifier block connects through the slave modport.
interface a12_edge_qual_if;
  logic       ppu_a12;
  logic       en;
  logic       edge_ack;
  logic       drop_clr;
  logic       edge_pend;
  logic       edge_pulse;
  logic       a12_sync;
  logic [7:0] drop_cnt;
  logic       low_sat;

  modport master (
    output ppu_a12, en, edge_ack, drop_clr,
    input  edge_pend, edge_pulse, a12_sync, drop_cnt, low_sat
  );

  modport slave (
    input  ppu_a12, en, edge_ack, drop_clr,
    output edge_pend, edge_pulse, a12_sync, drop_cnt, low_sat
  );
endinterface

// File: rtl/a12_edge_qual.sv
// PPU A12 rise qualifier feeding the MMC3-style scanline counter: synchronizes A12,
// measures low time and holds qualified events. Define A12_HIGH_QUAL_EN for high-time confirmation.
module a12_edge_qual #(
  parameter int LOW_MIN     = 24,
  parameter int HIGH_MIN    = 3,
  parameter int SYNC_STAGES = 2
) (
  input logic            clk,
  input logic            rst_n,
  a12_edge_qual_if.slave bus
);

  localparam logic [7:0] LOW_MIN_C = 8'(LOW_MIN);

  if ((LOW_MIN < 1) || (LOW_MIN > 255)) begin : g_bad_low_min
    $error("LOW_MIN out of range");
  end
  if ((HIGH_MIN < 1) || (HIGH_MIN > 15)) begin : g_bad_high_min
    $error("HIGH_MIN out of range");
  end
  if ((SYNC_STAGES < 2) || (SYNC_STAGES > 3)) begin : g_bad_sync
    $error("SYNC_STAGES out of range");
  end

`ifdef A12_HIGH_QUAL_EN
  localparam logic [3:0] HIGH_MIN_C = 4'(HIGH_MIN);
  typedef enum logic [1:0] {
    ST_HIGH    = 2'd0,
    ST_LOW     = 2'd1,
    ST_ARMED   = 2'd2,
    ST_CONFIRM = 2'd3
  } state_t;
  logic [3:0] hi_cnt_r;
`else
  typedef enum logic [1:0] {
    ST_HIGH  = 2'd0,
    ST_LOW   = 2'd1,
    ST_ARMED = 2'd2
  } state_t;
`endif

  state_t                 state_r;
  logic [SYNC_STAGES-1:0] sync_r;
  logic                   a12_s;
  logic [7:0]             low_cnt_r;
  logic [7:0]             low_cnt_nxt_s;
  logic                   low_sat_r;
  logic                   hold_low_s;
  logic                   edge_pulse_r;
  logic                   edge_pend_r;
  logic [7:0]             drop_cnt_r;

  assign a12_s          = sync_r[SYNC_STAGES-1];
  assign bus.a12_sync   = a12_s;
  assign bus.low_sat    = low_sat_r;
  assign bus.edge_pulse = edge_pulse_r;
  assign bus.edge_pend  = edge_pend_r;
  assign bus.drop_cnt   = drop_cnt_r;

  // Metastability synchronizer for the asynchronous A12 input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], bus.ppu_a12};
    end
  end

  // A high glitch during confirmation must not discard the low time already measured
`ifdef A12_HIGH_QUAL_EN
  assign hold_low_s = (state_r == ST_ARMED) || (state_r == ST_CONFIRM);
`else
  assign hold_low_s = 1'b0;
`endif

  // Next low-time count: saturating at LOW_MIN, cleared by a high sample or disable
  always_comb begin
    low_cnt_nxt_s = low_cnt_r;
    if (!bus.en) begin
      low_cnt_nxt_s = 8'd0;
    end else if (hold_low_s) begin
      low_cnt_nxt_s = low_cnt_r;
    end else if (a12_s) begin
      low_cnt_nxt_s = 8'd0;
    end else if (low_cnt_r < LOW_MIN_C) begin
      low_cnt_nxt_s = low_cnt_r + 8'd1;
    end else begin
      low_cnt_nxt_s = low_cnt_r;
    end
  end

  // Low-time counter and its saturation flag, kept in lockstep
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      low_cnt_r <= 8'd0;
      low_sat_r <= 1'b0;
    end else begin
      low_cnt_r <= low_cnt_nxt_s;
      low_sat_r <= (low_cnt_nxt_s == LOW_MIN_C);
    end
  end

  // Qualification state machine with registered event strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_HIGH;
      edge_pulse_r <= 1'b0;
`ifdef A12_HIGH_QUAL_EN
      hi_cnt_r     <= 4'd0;
`endif
    end else begin
      edge_pulse_r <= 1'b0;
      if (!bus.en) begin
        state_r <= ST_HIGH;
`ifdef A12_HIGH_QUAL_EN
        hi_cnt_r <= 4'd0;
`endif
      end else begin
        case (state_r)
          ST_HIGH: begin
            if (!a12_s) begin
              state_r <= ST_LOW;
            end else begin
              state_r <= ST_HIGH;
            end
          end
          ST_LOW: begin
            if (a12_s) begin
              state_r <= ST_HIGH;
            end else if (low_sat_r) begin
              state_r <= ST_ARMED;
            end else begin
              state_r <= ST_LOW;
            end
          end
          ST_ARMED: begin
            if (a12_s) begin
`ifdef A12_HIGH_QUAL_EN
              if (HIGH_MIN_C <= 4'd1) begin
                edge_pulse_r <= 1'b1;
                state_r      <= ST_HIGH;
              end else begin
                hi_cnt_r <= 4'd1;
                state_r  <= ST_CONFIRM;
              end
`else
              edge_pulse_r <= 1'b1;
              state_r      <= ST_HIGH;
`endif
            end else begin
              state_r <= ST_ARMED;
            end
          end
`ifdef A12_HIGH_QUAL_EN
          ST_CONFIRM: begin
            if (!a12_s) begin
              hi_cnt_r <= 4'd0;
              state_r  <= ST_ARMED;
            end else if ((hi_cnt_r + 4'd1) >= HIGH_MIN_C) begin
              hi_cnt_r     <= 4'd0;
              edge_pulse_r <= 1'b1;
              state_r      <= ST_HIGH;
            end else begin
              hi_cnt_r <= hi_cnt_r + 4'd1;
              state_r  <= ST_CONFIRM;
            end
          end
`endif
          default: begin
            state_r <= ST_HIGH;
          end
        endcase
      end
    end
  end

  // Pending flag (new event beats a same-cycle ack) and saturating drop counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_pend_r <= 1'b0;
      drop_cnt_r  <= 8'd0;
    end else begin
      if (edge_pulse_r) begin
        edge_pend_r <= 1'b1;
      end else if (bus.edge_ack) begin
        edge_pend_r <= 1'b0;
      end else begin
        edge_pend_r <= edge_pend_r;
      end
      if (bus.drop_clr) begin
        drop_cnt_r <= 8'd0;
      end else if (edge_pulse_r && edge_pend_r && !bus.edge_ack && (drop_cnt_r != 8'hFF)) begin
        drop_cnt_r <= drop_cnt_r + 8'd1;
      end else begin
        drop_cnt_r <= drop_cnt_r;
      end
    end
  end

endmodule

// File: tb/tb_a12_edge_qual.sv
// Directed bench for a12_edge_qual: expected pulse cycles are queued when a rise is driven
// and matched against observed edge_pulse strobes.
module tb_a12_edge_qual;
  localparam int LOW_MIN     = 24;
  localparam int HIGH_MIN    = 3;
  localparam int SYNC_STAGES = 2;
`ifdef A12_HIGH_QUAL_EN
  localparam int LAT = SYNC_STAGES + 1 + HIGH_MIN - 1;
`else
  localparam int LAT = SYNC_STAGES + 1;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   exp_q[$];

  always #5 clk = ~clk;

  a12_edge_qual_if bus ();

  a12_edge_qual #(
    .LOW_MIN    (LOW_MIN),
    .HIGH_MIN   (HIGH_MIN),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock; any strobe seen is matched against the scoreboard
  task automatic tick();
    int e;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.edge_pulse === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse_at_cycle", cyc, 0);
      end else begin
        e = exp_q.pop_front();
        chk("pulse_cycle", cyc, e);
      end
    end
  endtask

  // Long low, then a rise; optionally ack and/or clear drops in the pulse cycle
  task automatic valid_event(input bit ack_at, input bit clr_at);
    bus.ppu_a12 = 1'b0;
    repeat (30) tick();
    bus.ppu_a12 = 1'b1;
    exp_q.push_back(cyc + LAT);
    repeat (LAT) tick();
    bus.edge_ack = ack_at;
    bus.drop_clr = clr_at;
    tick();
    bus.edge_ack = 1'b0;
    bus.drop_clr = 1'b0;
    repeat (3) tick();
  endtask

  task automatic ack();
    bus.edge_ack = 1'b1;
    tick();
    bus.edge_ack = 1'b0;
  endtask

  initial begin
    bus.ppu_a12  = 1'b1;
    bus.en       = 1'b1;
    bus.edge_ack = 1'b0;
    bus.drop_clr = 1'b0;
    repeat (3) tick();
    chk("rst_edge_pend", bus.edge_pend, 0);
    chk("rst_edge_pulse", bus.edge_pulse, 0);
    chk("rst_a12_sync", bus.a12_sync, 0);
    chk("rst_drop_cnt", bus.drop_cnt, 0);
    chk("rst_low_sat", bus.low_sat, 0);
    rst_n = 1'b1;
    repeat (10) tick();
    chk("release_high_no_pend", bus.edge_pend, 0);

    // Basic event with synchronizer latency check
    bus.ppu_a12 = 1'b0;
    tick();
    chk("sync_lat_1", bus.a12_sync, 1);
    tick();
    chk("sync_lat_2", bus.a12_sync, 0);
    repeat (28) tick();
    chk("basic_low_sat", bus.low_sat, 1);
    bus.ppu_a12 = 1'b1;
    exp_q.push_back(cyc + LAT);
    repeat (LAT + 3) tick();
    chk("basic_pend", bus.edge_pend, 1);
    chk("basic_drop", bus.drop_cnt, 0);
    chk("basic_low_sat_clr", bus.low_sat, 0);
    ack();
    chk("basic_ack", bus.edge_pend, 0);

    // Short low: no event
    bus.ppu_a12 = 1'b0;
    repeat (10) tick();
    chk("short_low_sat", bus.low_sat, 0);
    bus.ppu_a12 = 1'b1;
    repeat (8) tick();
    chk("short_pend", bus.edge_pend, 0);

`ifdef A12_HIGH_QUAL_EN
    // One-sample high glitch after a valid low, then a proper high
    bus.ppu_a12 = 1'b0;
    repeat (30) tick();
    bus.ppu_a12 = 1'b1;
    tick();
    bus.ppu_a12 = 1'b0;
    repeat (4) tick();
    chk("glitch_low_sat_held", bus.low_sat, 1);
    chk("glitch_pend", bus.edge_pend, 0);
    bus.ppu_a12 = 1'b1;
    exp_q.push_back(cyc + LAT);
    repeat (LAT + 2) tick();
    chk("confirm_pend", bus.edge_pend, 1);
    ack();
`endif

    // Drops
    valid_event(1'b0, 1'b0);
    chk("drop_first_pend", bus.edge_pend, 1);
    chk("drop_first_cnt", bus.drop_cnt, 0);
    valid_event(1'b0, 1'b0);
    chk("drop_second_pend", bus.edge_pend, 1);
    chk("drop_second_cnt", bus.drop_cnt, 1);

    // Coincident ack and pulse: new event wins, no drop
    valid_event(1'b1, 1'b0);
    chk("ack_pulse_pend", bus.edge_pend, 1);
    chk("ack_pulse_drop", bus.drop_cnt, 1);

    // Coincident clear and drop: clear wins
    valid_event(1'b0, 1'b1);
    chk("clr_pulse_drop", bus.drop_cnt, 0);
    chk("clr_pulse_pend", bus.edge_pend, 1);

    ack();
    chk("ack_clears", bus.edge_pend, 0);
    ack();
    chk("ack_idle_ignored", bus.edge_pend, 0);

    // Saturation of drop counter
    for (int i = 0; i < 300; i++) begin
      valid_event(1'b0, 1'b0);
    end
    chk("drop_sat", bus.drop_cnt, 255);
    bus.drop_clr = 1'b1;
    tick();
    bus.drop_clr = 1'b0;
    chk("drop_clr", bus.drop_cnt, 0);

    // Reset while armed, released with A12 high
    ack();
    bus.ppu_a12 = 1'b0;
    repeat (30) tick();
    chk("armed_low_sat", bus.low_sat, 1);
    rst_n = 1'b0;
    bus.ppu_a12 = 1'b1;
    #1;
    chk("midrst_pend", bus.edge_pend, 0);
    chk("midrst_pulse", bus.edge_pulse, 0);
    chk("midrst_sync", bus.a12_sync, 0);
    chk("midrst_drop", bus.drop_cnt, 0);
    chk("midrst_low_sat", bus.low_sat, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (10) tick();
    chk("midrst_release_pend", bus.edge_pend, 0);

    // Disabled qualifier ignores a valid low/rise
    bus.en = 1'b0;
    bus.ppu_a12 = 1'b0;
    repeat (30) tick();
    chk("dis_low_sat", bus.low_sat, 0);
    bus.ppu_a12 = 1'b1;
    repeat (8) tick();
    chk("dis_pend", bus.edge_pend, 0);

    // Re-enable during low restarts the measurement
    bus.ppu_a12 = 1'b0;
    repeat (20) tick();
    bus.en = 1'b1;
    repeat (20) tick();
    chk("reen_not_sat", bus.low_sat, 0);
    repeat (10) tick();
    chk("reen_sat", bus.low_sat, 1);
    bus.ppu_a12 = 1'b1;
    exp_q.push_back(cyc + LAT);
    repeat (LAT + 2) tick();
    chk("reen_pend", bus.edge_pend, 1);

    chk("missing_pulses", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/a12_edge_qual.md
Name: a12_edge_qual

Overview:
- Upstream stage for the MMC3-family scanline counter.
- Samples asynchronous PPU A12 in the system clock domain and measures A12 low time.
- Emits one qualified "scanline clock" event per valid A12 rise, i.e. a rise preceded by a long-enough low period.
- Holds each event as a pending flag until the consumer (the mapper counter logic) acknowledges it. Edges that arrive while an event is still pending are counted as drops.

Parameters:
- LOW_MIN, 24: minimum consecutive synchronized-low clk cycles before a rise qualifies; legal range 1..255.
- HIGH_MIN, 3: minimum consecutive high clk cycles to confirm a rise; used only with A12_HIGH_QUAL_EN.
- SYNC_STAGES, 2: synchronizer depth for ppu_a12; legal range 2..3.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- ppu_a12  input  1  raw PPU address bit 12, asynchronous
- en  input  1  qualifier enable; when 0, no events are generated and low_cnt is held at 0
- edge_ack  input  1  consumer acknowledge, one clk pulse; clears edge_pend
- drop_clr  input  1  clears drop_cnt
- edge_pend  output  1  qualified rise pending
- edge_pulse  output  1  one-clk strobe in the cycle a rise qualifies
- a12_sync  output  1  synchronized A12 level
- drop_cnt  output  8  saturating count of qualified rises lost while edge_pend was already 1
- low_sat  output  1  low_cnt has reached LOW_MIN

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Synchronizer flops = 0.
  - state = ST_HIGH.
  - low_cnt = 0.
  - edge_pend, edge_pulse, low_sat = 0.
  - drop_cnt = 0.
  - Releasing reset with ppu_a12 already high must not generate an event.
- a12_sync: output of the last synchronizer stage. Latency from ppu_a12 to a12_sync = SYNC_STAGES clks.
- low_cnt: 8-bit. It increments while a12_sync=0, saturates at LOW_MIN, and clears on a12_sync=1. low_sat = (low_cnt == LOW_MIN).
- State machine, advanced on every clk:
  - ST_HIGH: waits for a12_sync=0, then goes to ST_LOW.
  - ST_LOW: counting low time.
    - a12_sync=1 before low_sat -> ST_HIGH, no event (short low or glitch).
    - low_sat=1 -> ST_ARMED.
  - ST_ARMED: waits for a12_sync=1.
    - On the first high sample: edge_pulse=1 for that cycle, then -> ST_HIGH.
- Qualification latency: edge_pulse is asserted SYNC_STAGES+1 clks after ppu_a12 rises, measured from an ST_ARMED condition.
- Event capture and acknowledge:
  - On edge_pulse, edge_pend is set in the next cycle.
  - edge_ack clears edge_pend.
  - If edge_pulse and edge_ack occur in the same cycle: edge_pend stays 1 (new event wins). drop_cnt does not change.
- Drop counting:
  - edge_pulse while edge_pend=1 and edge_ack=0 -> drop_cnt+1, saturating at 255.
  - drop_clr has priority over an increment in the same cycle.
- en=0:
  - State is forced to ST_HIGH and low_cnt to 0. edge_pend is preserved (an ack still clears it).
  - Re-enabling while A12 is low restarts low-time measurement from 0.
- Counter width rule: low_cnt never exceeds LOW_MIN and never wraps.
- edge_ack while edge_pend=0 is ignored.

Optional Feature:
- Macro A12_HIGH_QUAL_EN.
- Defined: adds state ST_CONFIRM between ST_ARMED and the event.
  - The first high sample moves the FSM to ST_CONFIRM. A 4-bit hi_cnt counts consecutive high clks.
  - On reaching HIGH_MIN: edge_pulse, then -> ST_HIGH.
  - Any low sample in ST_CONFIRM -> back to ST_ARMED with no event; low_cnt stays saturated because the prior low time is still valid.
  - Added latency: HIGH_MIN-1 clks.
- Undefined: no ST_CONFIRM and no hi_cnt; a single high sample in ST_ARMED qualifies the rise.

Test Plan:
- Basic event: LOW_MIN=24; hold A12 low 30 clks, then high -> exactly one edge_pulse 3 clks after the rise; edge_pend=1 until edge_ack; drop_cnt=0.
- Short low: A12 low 10 clks, then high -> no edge_pulse, edge_pend stays 0; state returns to ST_HIGH.
- Drops: two valid rises with no ack between them -> edge_pend=1, drop_cnt=1. Run 300 unacked valid rises -> drop_cnt saturates at 255. drop_clr -> drop_cnt=0.
- Simultaneous events: edge_ack coincident with edge_pulse -> edge_pend remains 1, drop_cnt unchanged. edge_pulse coincident with drop_clr -> drop_cnt=0.
- Reset mid-operation: assert rst_n=0 during ST_ARMED with A12 low, release with A12 high -> no edge_pulse; all outputs 0. en=0 during a 30-clk low followed by a rise -> no event.
- Glitch with A12_HIGH_QUAL_EN, HIGH_MIN=3: after a valid low, a 1-clk high then low -> no event. A following 3-clk high -> one edge_pulse.
